// File: rtl/prog_loader.sv
// ============================================================================
// Module   : prog_loader
// Purpose  : Byte-stream program loader. Receives an image
//            (HDR, N, N x {hi,lo} words[, checksum]) from a host byte link and
//            writes it into the CPU instruction memory. Holds the CPU halted
//            while loading and releases it only after a good image is stored.
// Config   : PROG_LOADER_CHECKSUM_EN - when defined, a trailing 8-bit checksum
//            byte (sum of all word bytes mod 256) is expected and verified.
// Ports    : CLK, RST_N      - clock (rising edge), async active-low reset
//            DIN/DIN_VALID   - incoming byte and its valid qualifier
//            DIN_READY       - always 1 outside reset (no back-pressure)
//            PM_ADDR/PM_DATA - instruction memory write address / word
//            PM_WE           - one-cycle write strobe
//            CPU_HOLD        - stalls the CPU while a load is in progress
//            DONE            - one-cycle pulse on successful load
//            ERR             - sticky error flag for the last load
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter int          WIDTH      = 13,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [7:0]  HDR        = 8'hA5
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  output logic [ADDR_WIDTH-1:0] PM_ADDR,
  output logic [WIDTH-1:0]      PM_DATA,
  output logic                  PM_WE,
  output logic                  CPU_HOLD,
  output logic                  DONE,
  output logic                  ERR
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3
`ifdef PROG_LOADER_CHECKSUM_EN
   ,ST_CSUM  = 3'd4
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [WIDTH-1:0]      data_q,  data_d;
  logic                  we_q,    we_d;
  logic                  hold_q,  hold_d;
  logic                  done_q,  done_d;
  logic                  err_q,   err_d;
  logic [8:0]            cnt_q,   cnt_d;    // words remaining (1..256)
  logic [WIDTH-9:0]      hi_q,    hi_d;     // upper word bits from the high byte
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q,  csum_d;
`endif

  logic                  w_acc;
  logic [7:0]            w_hi_upper;
  logic                  w_hi_illegal;

  // Ready simply follows reset: the loader never stalls the link.
  assign DIN_READY    = RST_N;
  assign w_acc        = DIN_VALID & DIN_READY;
  // High-byte bits above the word's top bit must be zero; for WIDTH=16 the
  // shift empties the byte so nothing is ever illegal.
  assign w_hi_upper   = DIN >> (WIDTH - 8);
  assign w_hi_illegal = |w_hi_upper;

  always_comb begin
    state_d = state_q;
    // Address advances in the cycle after each write strobe.
    addr_d  = we_q ? addr_q + 1'b1 : addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    // Hold drops the cycle after DONE; a header in that cycle re-asserts it.
    hold_d  = done_q ? 1'b0 : hold_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_acc && DIN == HDR) begin
          state_d = ST_COUNT;
          hold_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_COUNT: begin
        if (w_acc) begin
          cnt_d   = (DIN == 8'd0) ? 9'd256 : {1'b0, DIN};
          addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (w_acc) begin
          if (w_hi_illegal) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            hi_d    = DIN[WIDTH-9:0];
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d  = csum_q + DIN;
`endif
            state_d = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (w_acc) begin
          data_d = {hi_q, DIN};
          we_d   = 1'b1;
          cnt_d  = cnt_q - 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q + DIN;
`endif
          if (cnt_q == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = ST_HI;
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_acc) begin
          if (DIN == csum_q) done_d = 1'b1;
          else               err_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign PM_ADDR  = addr_q;
  assign PM_DATA  = data_q;
  assign PM_WE    = we_q;
  assign CPU_HOLD = hold_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Self-checking bench for prog_loader. Expected memory writes are
//            queued as stimulus is driven and compared as PM_WE strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  DIN;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic [7:0]  PM_ADDR;
  logic [12:0] PM_DATA;
  logic        PM_WE;
  logic        CPU_HOLD;
  logic        DONE;
  logic        ERR;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [20:0] exp_q[$];   // {addr, data}

  prog_loader dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .PM_ADDR   (PM_ADDR),
    .PM_DATA   (PM_DATA),
    .PM_WE     (PM_WE),
    .CPU_HOLD  (CPU_HOLD),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one cycle; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    DIN       = b;
    DIN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    DIN_VALID = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [12:0] d);
    exp_q.push_back({a, d});
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RST_N && PM_WE) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", PM_ADDR, PM_DATA);
      end
      if (exp_q.size() != 0) begin
        logic [20:0] e;
        e = exp_q.pop_front();
        chk("write", {11'd0, PM_ADDR, PM_DATA}, {11'd0, e});
      end
    end
    if (RST_N && DONE) done_cnt++;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, DIN_READY}, 32'd0);
    chk({tag, "_addr"},  {24'd0, PM_ADDR},   32'd0);
    chk({tag, "_data"},  {19'd0, PM_DATA},   32'd0);
    chk({tag, "_we"},    {31'd0, PM_WE},     32'd0);
    chk({tag, "_hold"},  {31'd0, CPU_HOLD},  32'd0);
    chk({tag, "_done"},  {31'd0, DONE},      32'd0);
    chk({tag, "_err"},   {31'd0, ERR},       32'd0);
  endtask

  initial begin
    logic [12:0] wd;
    logic [7:0]  cs;
    int          d0;

    RST_N     = 1'b0;
    DIN       = 8'h00;
    DIN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("rst");

    // Release reset; junk bytes in IDLE are ignored.
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, DIN_READY}, 32'd1);
    send(8'h00);
    send(8'h33);
    chk("junk_hold", {31'd0, CPU_HOLD}, 32'd0);
    chk("junk_err",  {31'd0, ERR},      32'd0);

    // Image A: two words, back-to-back.
    d0 = done_cnt;
    push_exp(8'd0, 13'h1FFF);
    push_exp(8'd1, 13'h0012);
    send(8'hA5);
    chk("A_hold_rise", {31'd0, CPU_HOLD}, 32'd1);
    send(8'h02);
    send(8'h1F);
    send(8'hFF);
    send(8'h00);
    send(8'h12);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h30);  // 1F+FF+00+12 = 0x130
`endif
    chk("A_done",      {31'd0, DONE},     32'd1);
    chk("A_hold_done", {31'd0, CPU_HOLD}, 32'd1);
    @(posedge CLK); #1;
    chk("A_hold_fall", {31'd0, CPU_HOLD}, 32'd0);
    chk("A_addr_next", {24'd0, PM_ADDR},  32'd2);
    chk("A_drained",   exp_q.size(),      32'd0);
    chk("A_done_once", done_cnt - d0,     32'd1);

    // Illegal upper bits in the high byte.
    d0 = done_cnt;
    send(8'hA5);
    send(8'h01);
    send(8'h20);
    chk("E_err",  {31'd0, ERR},      32'd1);
    send(8'h00);
    repeat (2) @(posedge CLK); #1;
    chk("E_err_sticky", {31'd0, ERR},      32'd1);
    chk("E_hold",       {31'd0, CPU_HOLD}, 32'd1);
    chk("E_no_done",    done_cnt - d0,     32'd0);

    // Recovery load clears ERR and releases the CPU.
    d0 = done_cnt;
    push_exp(8'd0, 13'h0102);
    send(8'hA5);
    chk("R_err_clr", {31'd0, ERR}, 32'd0);
    send(8'h01);
    send(8'h01);
    send(8'h02);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h03);
`endif
    chk("R_done", {31'd0, DONE}, 32'd1);
    @(posedge CLK); #1;
    chk("R_hold_fall", {31'd0, CPU_HOLD}, 32'd0);
    chk("R_done_once", done_cnt - d0,     32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Same image, wrong checksum: word is still written, load fails.
    d0 = done_cnt;
    push_exp(8'd0, 13'h0102);
    send(8'hA5);
    send(8'h01);
    send(8'h01);
    send(8'h02);
    send(8'h04);
    @(posedge CLK); #1;
    chk("C_err",     {31'd0, ERR},      32'd1);
    chk("C_hold",    {31'd0, CPU_HOLD}, 32'd1);
    chk("C_no_done", done_cnt - d0,     32'd0);
`endif

    // Full 256-word image (N = 0) at one byte per cycle.
    d0 = done_cnt;
    cs = 8'd0;
    send(8'hA5);
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      wd = 13'((i * 37 + 5) & 32'h1FFF);
      push_exp(8'(i), wd);
      cs = cs + {3'd0, wd[12:8]} + wd[7:0];
      send({3'd0, wd[12:8]});
      send(wd[7:0]);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send(cs);
`endif
    chk("F_done", {31'd0, DONE}, 32'd1);
    @(posedge CLK); #1;
    chk("F_addr_wrap", {24'd0, PM_ADDR},  32'd0);
    chk("F_hold_fall", {31'd0, CPU_HOLD}, 32'd0);
    chk("F_done_once", done_cnt - d0,     32'd1);
    chk("F_drained",   exp_q.size(),      32'd0);

    // Reset in the middle of a load.
    send(8'hA5);
    send(8'h02);
    send(8'h1F);
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge CLK);
    RST_N = 1'b1;
    d0 = done_cnt;
    push_exp(8'd0, 13'h0007);
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h07);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h07);
`endif
    chk("M_done", {31'd0, DONE}, 32'd1);
    @(posedge CLK); #1;
    chk("M_hold_fall", {31'd0, CPU_HOLD}, 32'd0);
    chk("M_done_once", done_cnt - d0,     32'd1);
    chk("M_drained",   exp_q.size(),      32'd0);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
